// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, response and main-memory signals of the memory arbiter
//   master : arbiter view (takes requests and mem responses, drives readies and mem strobes)
//   slave  : environment view (requesters plus main memory)
interface mem_arbiter_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        dmem_re;
   logic        dmem_wr;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic        err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_re;
   logic        mem_wr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   modport master (
      input  imem_req, imem_addr, dmem_re, dmem_wr, dmem_addr, dmem_wdata, mem_rdata, mem_ready,
      output imem_rdata, imem_ready, dmem_rdata, dmem_ready, err, mem_addr, mem_wdata, mem_re, mem_wr
   );
   modport slave (
      output imem_req, imem_addr, dmem_re, dmem_wr, dmem_addr, dmem_wdata, mem_rdata, mem_ready,
      input  imem_rdata, imem_ready, dmem_rdata, dmem_ready, err, mem_addr, mem_wdata, mem_re, mem_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between instruction fetch and load/store
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : requester inputs, registered mem strobes/address/wdata, rdata + one-cycle ready/err pulses
module mem_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic            clk,
   input logic            rst,
   mem_arbiter_if.master  bus
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
   state_t      state, state_nxt;
   logic [3:0]  starve_cnt;
   logic [7:0]  timer;
   logic        grant_d, grant_i, busy, ack, tout;
   // data wins unless a fetch has already waited STARVE_LIMIT data grants
   assign grant_d = (bus.dmem_re | bus.dmem_wr) & ~(bus.imem_req & (starve_cnt == 4'(STARVE_LIMIT)));
   assign grant_i = ~grant_d & bus.imem_req;
   assign busy    = (state == BUSY_I) | (state == BUSY_D);
   assign ack     = busy & bus.mem_ready;
   assign tout    = busy & ~bus.mem_ready & (timer == 8'(TIMEOUT_CYCLES - 1));
   always_comb begin
      state_nxt = state;
      if (state == IDLE)
         state_nxt = grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
      else if (state == DONE)
         state_nxt = IDLE;
      else if (ack | tout)
         state_nxt = DONE;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt     <= '0;
         timer          <= '0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_re     <= 1'b0;
         bus.mem_wr     <= 1'b0;
         bus.imem_rdata <= '0;
         bus.dmem_rdata <= '0;
         bus.imem_ready <= 1'b0;
         bus.dmem_ready <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.imem_ready <= 1'b0;
         bus.dmem_ready <= 1'b0;
         bus.err        <= 1'b0;
         if (state == IDLE) begin
            if (grant_d) begin
               bus.mem_addr <= bus.dmem_addr;
               bus.mem_wr   <= bus.dmem_wr;
               bus.mem_re   <= ~bus.dmem_wr;
               timer        <= '0;
               if (bus.dmem_wr) bus.mem_wdata <= bus.dmem_wdata;
               if (bus.imem_req && starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
            end else if (grant_i) begin
               bus.mem_addr <= bus.imem_addr;
               bus.mem_re   <= 1'b1;
               bus.mem_wr   <= 1'b0;
               timer        <= '0;
               starve_cnt   <= '0;
            end
         end else if (busy) begin
            if (ack | tout) begin
               bus.mem_re <= 1'b0;
               bus.mem_wr <= 1'b0;
               bus.err    <= tout;
               // completed writes and aborted accesses return zero
               if (state == BUSY_I) begin
                  bus.imem_ready <= 1'b1;
                  bus.imem_rdata <= tout ? 32'h0 : bus.mem_rdata;
               end else begin
                  bus.dmem_ready <= 1'b1;
                  bus.dmem_rdata <= (tout | bus.mem_wr) ? 32'h0 : bus.mem_rdata;
               end
            end else begin
               timer <= timer + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table, hand-written and random checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
   localparam int SL = 4;
   localparam int TO = 8;
   logic clk, rst;
   int   total = 0, bad = 0;
   mem_arbiter_if bus();
   mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic        ireq, dre, dwr;
      logic [31:0] iaddr, daddr, wdata, rdata;
      int          delay;
      logic        exp_d, exp_wr, exp_err;
      logic [31:0] exp_addr, exp_rdata;
      int          exp_cyc;
   } vec_t;
   vec_t vecs[7];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic set_req(input logic ir, input logic dre, input logic dwr, input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
      bus.imem_req = ir; bus.dmem_re = dre; bus.dmem_wr = dwr;
      bus.imem_addr = ia; bus.dmem_addr = da; bus.dmem_wdata = wd;
   endtask
   // runs one transaction from IDLE: grant edge, memory answering after delay strobe cycles, DONE, back to IDLE
   task automatic txn(input int delay, input logic [31:0] rd, output logic [31:0] a, output logic [31:0] wd,
                      output logic re, output logic wr, output logic ok, output int cyc,
                      output logic ir, output logic dr, output logic e);
      @(posedge clk); #1;
      a = bus.mem_addr; wd = bus.mem_wdata; re = bus.mem_re; wr = bus.mem_wr; ok = 1'b1; cyc = 0;
      while ((bus.mem_re || bus.mem_wr) && cyc < 300) begin
         cyc++;
         if (bus.mem_addr !== a || bus.mem_wdata !== wd || bus.mem_re !== re || bus.mem_wr !== wr) ok = 1'b0;
         if (bus.imem_ready || bus.dmem_ready) ok = 1'b0;
         bus.mem_ready = cyc > delay;
         bus.mem_rdata = rd;
         @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      ir = bus.imem_ready; dr = bus.dmem_ready; e = bus.err;
      @(posedge clk); #1;
      if (bus.imem_ready || bus.dmem_ready || bus.err || bus.mem_re || bus.mem_wr) ok = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask
   logic [31:0] a, wd, mi, md, rd, ia, da, wdat, exp_rd;
   logic        re, wr, ok, ir, dr, e, ri, rre, rwr, is_d, w, exp_err;
   int          cyc, delay, starve, exp_cyc;
   initial begin
      vecs[0] = '{1, 0, 0, 32'h100,  32'h0,    32'h0,        32'hDEADBEEF, 1,   0, 0, 0, 32'h100,  32'hDEADBEEF, 2};
      vecs[1] = '{1, 1, 0, 32'h100,  32'h2000, 32'h0,        32'h12345678, 0,   1, 0, 0, 32'h2000, 32'h12345678, 1};
      vecs[2] = '{1, 0, 0, 32'h100,  32'h0,    32'h0,        32'hCAFEF00D, 0,   0, 0, 0, 32'h100,  32'hCAFEF00D, 1};
      vecs[3] = '{0, 1, 1, 32'h0,    32'h3000, 32'h55AA55AA, 32'hFFFFFFFF, 2,   1, 1, 0, 32'h3000, 32'h0,        3};
      vecs[4] = '{0, 1, 0, 32'h0,    32'h4000, 32'h0,        32'h11111111, 100, 1, 0, 1, 32'h4000, 32'h0,        8};
      vecs[5] = '{1, 0, 0, 32'h200,  32'h0,    32'h0,        32'h22222222, 50,  0, 0, 1, 32'h200,  32'h0,        8};
      vecs[6] = '{0, 0, 1, 32'h0,    32'h4400, 32'h0BADF00D, 32'h33333333, 7,   1, 1, 0, 32'h4400, 32'h0,        8};
      set_req(0, 0, 0, 0, 0, 0);
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
      do_reset();
      chk("reset_mem_addr", bus.mem_addr, 0);
      chk("reset_strobes", {bus.mem_re, bus.mem_wr, bus.mem_wdata}, 0);
      chk("reset_resp", {bus.imem_ready, bus.dmem_ready, bus.err, bus.imem_rdata, bus.dmem_rdata}, 0);
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_ack_ignored", {bus.mem_re, bus.mem_wr, bus.imem_ready, bus.dmem_ready, bus.err}, 0);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         set_req(vecs[i].ireq, vecs[i].dre, vecs[i].dwr, vecs[i].iaddr, vecs[i].daddr, vecs[i].wdata);
         txn(vecs[i].delay, vecs[i].rdata, a, wd, re, wr, ok, cyc, ir, dr, e);
         set_req(0, 0, 0, 0, 0, 0);
         chk($sformatf("v%0d_addr", i), a, vecs[i].exp_addr);
         chk($sformatf("v%0d_re_wr", i), {re, wr}, {~vecs[i].exp_wr, vecs[i].exp_wr});
         if (vecs[i].exp_wr) chk($sformatf("v%0d_wdata", i), wd, vecs[i].wdata);
         chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
         chk($sformatf("v%0d_stable", i), ok, 1);
         chk($sformatf("v%0d_ready", i), {ir, dr}, {~vecs[i].exp_d, vecs[i].exp_d});
         chk($sformatf("v%0d_err", i), e, vecs[i].exp_err);
         chk($sformatf("v%0d_rdata", i), vecs[i].exp_d ? bus.dmem_rdata : bus.imem_rdata, vecs[i].exp_rdata);
      end
      // starvation: fetch held while writes keep coming
      for (int n = 0; n < 5; n++) begin
         set_req(1, 0, 1, 32'h100, 32'h5000, 32'hA0 + n);
         txn(0, 32'h44444444, a, wd, re, wr, ok, cyc, ir, dr, e);
         if (n < SL) begin
            chk($sformatf("starve%0d_wr", n), {re, wr, dr}, 3'b011);
            chk($sformatf("starve%0d_addr", n), a, 32'h5000);
            chk($sformatf("starve%0d_wdata", n), wd, 32'hA0 + n);
         end else begin
            chk("starve_fetch", {re, wr, ir}, 3'b101);
            chk("starve_fetch_addr", a, 32'h100);
            chk("starve_fetch_rdata", bus.imem_rdata, 32'h44444444);
         end
      end
      set_req(1, 1, 0, 32'h180, 32'h5100, 0);
      txn(0, 32'h55555555, a, wd, re, wr, ok, cyc, ir, dr, e);
      chk("starve_cleared_data_wins", {dr, a}, {1'b1, 32'h5100});
      // asynchronous reset during a write
      set_req(0, 0, 1, 0, 32'h6000, 32'h66666666);
      @(posedge clk); #1;
      chk("midop_wr_before", {bus.mem_wr, bus.mem_addr}, {1'b1, 32'h6000});
      #2 rst = 1'b0;
      #1;
      chk("midop_async_drop", {bus.mem_wr, bus.mem_re, bus.mem_addr, bus.imem_ready, bus.dmem_ready, bus.err}, 0);
      set_req(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk("midop_no_pulse", {bus.dmem_ready, bus.err, bus.mem_wr}, 0);
      set_req(1, 0, 0, 32'h700, 0, 0);
      txn(0, 32'h77777777, a, wd, re, wr, ok, cyc, ir, dr, e);
      set_req(0, 0, 0, 0, 0, 0);
      chk("post_reset_fetch", {ir, dr, e, re, a}, {4'b1001, 32'h700});
      chk("post_reset_rdata", bus.imem_rdata, 32'h77777777);
      // random traffic against the rule-level model
      do_reset();
      starve = 0; mi = 0; md = 0;
      for (int n = 0; n < 40; n++) begin
         ri = 1'($urandom_range(0, 1)); rre = 1'($urandom_range(0, 1)); rwr = 1'($urandom_range(0, 1));
         delay = $urandom_range(0, 10); rd = $urandom(); ia = $urandom(); da = $urandom(); wdat = $urandom();
         set_req(ri, rre, rwr, ia, da, wdat);
         if (!ri && !rre && !rwr) begin
            @(posedge clk); #1;
            chk("rnd_idle", {bus.mem_re, bus.mem_wr}, 0);
            continue;
         end
         is_d = (rre || rwr) && !(ri && starve == SL);
         if (is_d && ri) starve = starve < SL ? starve + 1 : SL;
         else if (!is_d) starve = 0;
         w = is_d && rwr;
         exp_cyc = delay + 1 < TO ? delay + 1 : TO;
         exp_err = delay + 1 > TO;
         exp_rd = (exp_err || w) ? 32'h0 : rd;
         if (is_d) md = exp_rd; else mi = exp_rd;
         txn(delay, rd, a, wd, re, wr, ok, cyc, ir, dr, e);
         set_req(0, 0, 0, 0, 0, 0);
         chk($sformatf("rnd%0d_addr", n), a, is_d ? da : ia);
         chk($sformatf("rnd%0d_re_wr", n), {re, wr}, {~w, w});
         if (w) chk($sformatf("rnd%0d_wdata", n), wd, wdat);
         chk($sformatf("rnd%0d_cycles", n), cyc, exp_cyc);
         chk($sformatf("rnd%0d_stable", n), ok, 1);
         chk($sformatf("rnd%0d_ready_err", n), {ir, dr, e}, {~is_d, is_d, exp_err});
         chk($sformatf("rnd%0d_irdata", n), bus.imem_rdata, mi);
         chk($sformatf("rnd%0d_drdata", n), bus.dmem_rdata, md);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
